// File: rtl/uart_pg_pkg.sv
// Shared types and default timing constants for the UART program-memory loader.
package uart_pg_pkg;

  localparam int DEFAULT_CLKS_PER_BIT   = 87;       // 10 MHz / 115200 baud
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [1:0] {
    RX_WAIT_START,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_DAT_LO,
    LD_DAT_HI,
    LD_WRITE,
    LD_DONE
  } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// valid/error pulses depending on the stop bit.
module uart_rx_byte
  import uart_pg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       byte_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic            sync0_reg, sync1_reg;
  logic            rxd_sync;
  rx_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            vld_reg, vld_next;
  logic            err_reg, err_next;

  // Synchroniser flops reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_reg <= 1'b1;
      sync1_reg <= 1'b1;
    end else begin
      sync0_reg <= rxd;
      sync1_reg <= sync0_reg;
    end
  end

  assign rxd_sync = sync1_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RX_WAIT_START;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      vld_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      vld_reg   <= vld_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    vld_next   = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      RX_WAIT_START: begin
        if (!rxd_sync) begin
          state_next = RX_START;
          cnt_next   = '0;
        end
      end
      RX_START: begin
        // Re-check at mid start bit so short low glitches are ignored.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rxd_sync ? RX_WAIT_START : RX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxd_sync, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          vld_next   = rxd_sync;
          err_next   = !rxd_sync;
          state_next = RX_WAIT_START;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_WAIT_START;
    endcase
  end

  assign byte_o     = shift_reg;
  assign byte_vld_o = vld_reg;
  assign byte_err_o = err_reg;

endmodule

// File: rtl/uart_pg_loader.sv
// UART download master: receives a little-endian length word followed by that
// many 16-bit words and writes them to consecutive program-memory addresses.
module uart_pg_loader
  import uart_pg_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ADR_W          = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             uart_rxd,
  output logic             pg_rst_o,
  output logic             pg_wen_o,
  output logic [15:0]      pg_din_o,
  output logic [ADR_W-1:0] pg_adr_o,
  output logic             pg_done_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]       rx_byte;
  logic             byte_vld, byte_err;

  ld_state_t        state_reg, state_next;
  logic [15:0]      remain_reg, remain_next;
  logic [7:0]       lo_reg, lo_next;
  logic [15:0]      din_reg, din_next;
  logic [ADR_W-1:0] adr_reg, adr_next;
  logic             pg_rst_reg, pg_rst_next;
  logic             done_reg, done_next;
  logic             ferr_reg, ferr_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             busy, counting, abort;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .rxd        (uart_rxd),
    .byte_o     (rx_byte),
    .byte_vld_o (byte_vld),
    .byte_err_o (byte_err)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg  <= LD_IDLE;
      remain_reg <= '0;
      lo_reg     <= '0;
      din_reg    <= '0;
      adr_reg    <= '0;
      pg_rst_reg <= 1'b0;
      done_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
      lo_reg     <= lo_next;
      din_reg    <= din_next;
      adr_reg    <= adr_next;
      pg_rst_reg <= pg_rst_next;
      done_reg   <= done_next;
      ferr_reg   <= ferr_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  assign busy     = (state_reg != LD_IDLE) && (state_reg != LD_DONE);
  assign counting = (state_reg == LD_LEN_HI) || (state_reg == LD_DAT_LO) ||
                    (state_reg == LD_DAT_HI);
  assign abort    = busy && (byte_err || (counting && to_cnt_reg == TO_LAST));

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    lo_next     = lo_reg;
    din_next    = din_reg;
    adr_next    = adr_reg;
    pg_rst_next = pg_rst_reg;
    done_next   = done_reg;
    ferr_next   = ferr_reg;
    to_cnt_next = (byte_vld || !counting) ? '0 : to_cnt_reg + 1'b1;
    case (state_reg)
      LD_IDLE, LD_DONE: begin
        if (byte_vld) begin
          lo_next     = rx_byte;
          pg_rst_next = 1'b1;
          done_next   = 1'b0;
          ferr_next   = 1'b0;
          adr_next    = '0;
          state_next  = LD_LEN_HI;
        end else if (byte_err) begin
          ferr_next = 1'b1;
        end
      end
      LD_LEN_HI: begin
        if (byte_vld) begin
          remain_next = {rx_byte, lo_reg};
          if ({rx_byte, lo_reg} == 16'd0) begin
            pg_rst_next = 1'b0;
            done_next   = 1'b1;
            state_next  = LD_DONE;
          end else begin
            state_next = LD_DAT_LO;
          end
        end
      end
      LD_DAT_LO: begin
        if (byte_vld) begin
          lo_next    = rx_byte;
          state_next = LD_DAT_HI;
        end
      end
      LD_DAT_HI: begin
        // Output data only changes here, so it stays stable outside WRITE.
        if (byte_vld) begin
          din_next   = {rx_byte, lo_reg};
          state_next = LD_WRITE;
        end
      end
      LD_WRITE: begin
        adr_next    = adr_reg + 1'b1;
        remain_next = remain_reg - 1'b1;
        if (remain_reg == 16'd1) begin
          pg_rst_next = 1'b0;
          done_next   = 1'b1;
          state_next  = LD_DONE;
        end else begin
          state_next = LD_DAT_LO;
        end
      end
      default: state_next = LD_IDLE;
    endcase
    // Aborted loads keep the words already written; only control is dropped.
    if (abort) begin
      state_next  = LD_IDLE;
      ferr_next   = 1'b1;
      pg_rst_next = 1'b0;
      done_next   = 1'b0;
    end
  end

  assign pg_rst_o    = pg_rst_reg;
  assign pg_wen_o    = (state_reg == LD_WRITE);
  assign pg_din_o    = din_reg;
  assign pg_adr_o    = adr_reg;
  assign pg_done_o   = done_reg;
  assign frame_err_o = ferr_reg;
  assign busy_o      = busy;

endmodule

// File: tb/tb_uart_pg_loader.sv
// Directed bench for uart_pg_loader: a queue of expected writes is checked
// every cycle, plus literal checks of status levels after each scenario.
module tb_uart_pg_loader;

  localparam int CPB   = 32;
  localparam int TO    = 1000;
  localparam int ADR_W = 16;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b0;
  logic             uart_rxd = 1'b1;
  logic             pg_rst_o, pg_wen_o, pg_done_o, frame_err_o, busy_o;
  logic [15:0]      pg_din_o;
  logic [ADR_W-1:0] pg_adr_o;

  int tests = 0;
  int fails = 0;
  int n_writes = 0;

  typedef struct {
    logic [15:0] adr;
    logic [15:0] din;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         cur;
  logic [15:0] model_din = 16'h0;

  uart_pg_loader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TO),
    .ADR_W         (ADR_W)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .uart_rxd    (uart_rxd),
    .pg_rst_o    (pg_rst_o),
    .pg_wen_o    (pg_wen_o),
    .pg_din_o    (pg_din_o),
    .pg_adr_o    (pg_adr_o),
    .pg_done_o   (pg_done_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [15:0] adr, input logic [15:0] din);
    wr_t w;
    w.adr = adr;
    w.din = din;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    $display("[TB] tx byte %02h stop=%0b", b, stop_bit);
    @(negedge wb_clk_i) uart_rxd = 1'b0;
    repeat (CPB) @(negedge wb_clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge wb_clk_i);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge wb_clk_i);
    if (!stop_bit) begin
      uart_rxd = 1'b1;
      repeat (2 * CPB) @(negedge wb_clk_i);
    end
  endtask

  task automatic check_status(input string tag, input logic done, input logic rst,
                              input logic ferr, input logic bsy);
    check({tag, "_done"}, pg_done_o, done);
    check({tag, "_pg_rst"}, pg_rst_o, rst);
    check({tag, "_frame_err"}, frame_err_o, ferr);
    check({tag, "_busy"}, busy_o, bsy);
  endtask

  // Write checker: every strobe must match the next expected word; between
  // strobes the data bus must hold the last word written.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      model_din = 16'h0;
    end else if (pg_wen_o) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got adr %0h din %0h required no write", pg_adr_o, pg_din_o);
      end else begin
        cur = exp_q.pop_front();
        $display("[TB] write adr=%04h din=%04h (expected adr=%04h din=%04h)",
                 pg_adr_o, pg_din_o, cur.adr, cur.din);
        check("write_adr", pg_adr_o, cur.adr);
        check("write_din", pg_din_o, cur.din);
        check("write_pg_rst", pg_rst_o, 1'b1);
        model_din = cur.din;
      end
    end else begin
      check("din_hold", pg_din_o, model_din);
    end
  end

  initial begin
    #2 wb_rst_i = 1'b1;
    #1;
    check("reset_wen", pg_wen_o, 1'b0);
    check("reset_din", pg_din_o, 16'h0);
    check("reset_adr", pg_adr_o, 16'h0);
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (10) @(negedge wb_clk_i);

    // Normal two-word load
    expect_write(16'h0000, 16'h1234);
    expect_write(16'h0001, 16'hABCD);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hAB, 1'b1);
    repeat (5) @(negedge wb_clk_i);
    check_status("normal", 1'b1, 1'b0, 1'b0, 1'b0);
    check("normal_nwrites", n_writes, 2);
    check("normal_din_last", pg_din_o, 16'hABCD);
    check("normal_adr_after", pg_adr_o, 16'h0002);

    // Short low glitch must not start a byte
    @(negedge wb_clk_i) uart_rxd = 1'b0;
    repeat (10) @(negedge wb_clk_i);
    uart_rxd = 1'b1;
    repeat (200) @(negedge wb_clk_i);
    check_status("glitch", 1'b1, 1'b0, 1'b0, 1'b0);

    // Zero-length frame
    send_byte(8'h00, 1'b1);
    check("zero_first_pg_rst", pg_rst_o, 1'b1);
    send_byte(8'h00, 1'b1);
    check_status("zero", 1'b1, 1'b0, 1'b0, 1'b0);
    check("zero_nwrites", n_writes, 2);

    // Reload after a completed load
    send_byte(8'h01, 1'b1);
    check_status("reload_start", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_write(16'h0000, 16'hBEEF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    repeat (5) @(negedge wb_clk_i);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    check("reload_nwrites", n_writes, 3);

    // Bad stop bit on the first data byte
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (CPB) @(negedge wb_clk_i);
    check_status("badstop", 1'b0, 1'b0, 1'b1, 1'b0);
    check("badstop_nwrites", n_writes, 3);

    // Timeout after one of three words
    expect_write(16'h0000, 16'h1234);
    send_byte(8'h03, 1'b1);
    check("timeout_ferr_cleared", frame_err_o, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (500) @(negedge wb_clk_i);
    check_status("timeout_pending", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (TO + 10 - 500) @(negedge wb_clk_i);
    check_status("timeout", 1'b0, 1'b0, 1'b1, 1'b0);
    check("timeout_nwrites", n_writes, 4);

    // Asynchronous reset in the middle of a byte
    send_byte(8'h05, 1'b1);
    check("midrst_pg_rst_before", pg_rst_o, 1'b1);
    @(negedge wb_clk_i) uart_rxd = 1'b0;
    repeat (4 * CPB) @(negedge wb_clk_i);
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_din", pg_din_o, 16'h0);
    check("midrst_adr", pg_adr_o, 16'h0);
    check("midrst_wen", pg_wen_o, 1'b0);
    uart_rxd = 1'b1;
    repeat (20) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (10) @(negedge wb_clk_i);

    // Fresh frame after reset; the interrupted byte must be gone
    expect_write(16'h0000, 16'hBEEF);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    repeat (5) @(negedge wb_clk_i);
    check_status("postrst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("postrst_nwrites", n_writes, 5);
    check("postrst_adr", pg_adr_o, 16'h0001);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
